// File: rtl/gpu_copy_pkg.sv
// Shared types and constants for the VRAM-to-VRAM copy engines.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gpu_copy_pkg;

  localparam int VRAM_XW = 10;  // 1024 pixels wide
  localparam int VRAM_YW = 9;   // 512 lines high

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } cv_wr_state_t;

  localparam logic [1:0] PIXSEL_LEFT  = 2'b01;
  localparam logic [1:0] PIXSEL_RIGHT = 2'b10;
  localparam logic [1:0] PIXSEL_BOTH  = 2'b11;

endpackage

// File: rtl/cv_line_walker.sv
// Destination-rectangle walker: pair X / line Y / pair and line counters plus edge flags.
// Latency: counters update on the clock edge after i_load or i_step; flags are decoded from registers.
// Backpressure: none; advances only when i_step is high.
//
// Ports: i_load latches the rectangle (dstX, dstY, w, h); i_step advances one pair.
//        o_pairX/o_y give the current word position; o_first/o_last mark the line edges,
//        o_lastLine the final line; o_startOdd/o_endOdd give the parity of the line's end pixels.
module cv_line_walker
  import gpu_copy_pkg::*;
#(
  parameter int XW = VRAM_XW,
  parameter int YW = VRAM_YW
) (
  input  logic          clk,
  input  logic          nRst,
  input  logic          i_load,
  input  logic [XW-1:0] i_dstX,
  input  logic [YW-1:0] i_dstY,
  input  logic [XW:0]   i_w,
  input  logic [YW:0]   i_h,
  input  logic          i_step,
  output logic [XW-2:0] o_pairX,
  output logic [YW-1:0] o_y,
  output logic          o_first,
  output logic          o_last,
  output logic          o_lastLine,
  output logic          o_startOdd,
  output logic          o_endOdd
);

  logic [XW-2:0] base_x_q, base_x_d;
  logic          start_odd_q, start_odd_d;
  logic          end_odd_q, end_odd_d;
  logic [XW:0]   p_q, p_d;        // pairs per line, up to 513
  logic [YW:0]   h_q, h_d;
  logic [XW-2:0] pair_x_q, pair_x_d;
  logic [YW-1:0] y_q, y_d;
  logic [XW:0]   pair_q, pair_d;
  logic [YW:0]   line_q, line_d;

  logic [XW-1:0] end_x;
  logic [XW+1:0] p_sum;

  assign o_pairX    = pair_x_q;
  assign o_y        = y_q;
  assign o_first    = (pair_q == '0);
  assign o_last     = (pair_q == (p_q - (XW+1)'(1)));
  assign o_lastLine = (line_q == (h_q - (YW+1)'(1)));
  assign o_startOdd = start_odd_q;
  assign o_endOdd   = end_odd_q;

  always_comb begin
    base_x_d    = base_x_q;
    start_odd_d = start_odd_q;
    end_odd_d   = end_odd_q;
    p_d         = p_q;
    h_d         = h_q;
    pair_x_d    = pair_x_q;
    y_d         = y_q;
    pair_d      = pair_q;
    line_d      = line_q;
    end_x       = '0;
    p_sum       = '0;

    if (i_load) begin
      // Last pixel column wraps mod 1024; w=1024 has zero low bits, which still wraps correctly.
      end_x       = i_dstX + i_w[XW-1:0] - XW'(1);
      p_sum       = (XW+2)'(i_dstX[0]) + (XW+2)'(i_w) + (XW+2)'(1);
      base_x_d    = i_dstX[XW-1:1];
      start_odd_d = i_dstX[0];
      end_odd_d   = end_x[0];
      p_d         = p_sum[XW+1:1];
      h_d         = i_h;
      pair_x_d    = i_dstX[XW-1:1];
      y_d         = i_dstY;
      pair_d      = '0;
      line_d      = '0;
    end else if (i_step) begin
      if (!o_last) begin
        pair_d   = pair_q + (XW+1)'(1);
        pair_x_d = pair_x_q + (XW-1)'(1);   // wraps at 512 pairs
      end else begin
        pair_d   = '0;
        pair_x_d = base_x_q;
        y_d      = y_q + YW'(1);            // wraps 511 -> 0
        line_d   = line_q + (YW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      base_x_q    <= '0;
      start_odd_q <= 1'b0;
      end_odd_q   <= 1'b0;
      p_q         <= '0;
      h_q         <= '0;
      pair_x_q    <= '0;
      y_q         <= '0;
      pair_q      <= '0;
      line_q      <= '0;
    end else begin
      base_x_q    <= base_x_d;
      start_odd_q <= start_odd_d;
      end_odd_q   <= end_odd_d;
      p_q         <= p_d;
      h_q         <= h_d;
      pair_x_q    <= pair_x_d;
      y_q         <= y_d;
      pair_q      <= pair_d;
      line_q      <= line_d;
    end
  end

endmodule

// File: rtl/cv_write_state.sv
// Copy write engine: pops pixel pairs from the copy FIFO and issues masked 32-bit VRAM writes.
// Latency: pop-to-request 1 cycle; at most one pair per 2 cycles; done pulse 1 cycle after last ack.
// Backpressure: stalls in POP while the FIFO is empty; holds o_wrReq/adr/data/sel until i_wrAck.
//
// Ports: i_start + rectangle (i_dstX/i_dstY/i_w/i_h/i_forceMask); FIFO side i_fifoEmpty/o_fifoPop/
//        i_fifoData; VRAM side o_wrReq/o_wrAdr/o_wrData/o_wrSel/i_wrAck; status o_busy/o_done.
// Option: CVWRITE_FORCEMASK_EN enables forcing bit15 of both written pixels when i_forceMask is set.
module cv_write_state
  import gpu_copy_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int XW     = VRAM_XW,
  parameter int YW     = VRAM_YW
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              i_start,
  input  logic [XW-1:0]     i_dstX,
  input  logic [YW-1:0]     i_dstY,
  input  logic [XW:0]       i_w,
  input  logic [YW:0]       i_h,
  input  logic              i_forceMask,
  input  logic              i_fifoEmpty,
  output logic              o_fifoPop,
  input  logic [DATA_W-1:0] i_fifoData,
  output logic              o_wrReq,
  output logic [XW+YW-2:0]  o_wrAdr,
  output logic [DATA_W-1:0] o_wrData,
  output logic [1:0]        o_wrSel,
  input  logic              i_wrAck,
  output logic              o_busy,
  output logic              o_done
);

  cv_wr_state_t state_q, state_d;
  logic [XW+YW-2:0]  wr_adr_q, wr_adr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [1:0]        wr_sel_q, wr_sel_d;

  logic          walk_load, walk_step;
  logic [XW-2:0] walk_pair_x;
  logic [YW-1:0] walk_y;
  logic          walk_first, walk_last, walk_last_line;
  logic          walk_start_odd, walk_end_odd;
  logic [DATA_W-1:0] pop_data;

  cv_line_walker #(.XW(XW), .YW(YW)) u_walker (
    .clk        (clk),
    .nRst       (nRst),
    .i_load     (walk_load),
    .i_dstX     (i_dstX),
    .i_dstY     (i_dstY),
    .i_w        (i_w),
    .i_h        (i_h),
    .i_step     (walk_step),
    .o_pairX    (walk_pair_x),
    .o_y        (walk_y),
    .o_first    (walk_first),
    .o_last     (walk_last),
    .o_lastLine (walk_last_line),
    .o_startOdd (walk_start_odd),
    .o_endOdd   (walk_end_odd)
  );

`ifdef CVWRITE_FORCEMASK_EN
  logic force_mask_q, force_mask_d;

  always_comb begin
    force_mask_d = force_mask_q;
    if (state_q == IDLE && i_start) force_mask_d = i_forceMask;
  end

  always_ff @(posedge clk) begin
    if (!nRst) force_mask_q <= 1'b0;
    else       force_mask_q <= force_mask_d;
  end

  // bit15 of each 16-bit pixel is the mask bit
  assign pop_data = i_fifoData | (force_mask_q ? DATA_W'(32'h8000_8000) : '0);
`else
  logic unused_force_mask;
  assign unused_force_mask = i_forceMask;
  assign pop_data          = i_fifoData;
`endif

  assign o_wrAdr  = wr_adr_q;
  assign o_wrData = wr_data_q;
  assign o_wrSel  = wr_sel_q;

  always_comb begin
    state_d   = state_q;
    wr_adr_d  = wr_adr_q;
    wr_data_d = wr_data_q;
    wr_sel_d  = wr_sel_q;
    walk_load = 1'b0;
    walk_step = 1'b0;
    o_fifoPop = 1'b0;
    o_wrReq   = 1'b0;
    o_busy    = 1'b0;
    o_done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          walk_load = 1'b1;
          state_d   = POP;
        end
      end
      POP: begin
        o_busy = 1'b1;
        if (!i_fifoEmpty) begin
          o_fifoPop = 1'b1;
          wr_adr_d  = {walk_y, walk_pair_x};
          wr_data_d = pop_data;
          wr_sel_d  = PIXSEL_BOTH;
          // Edge pairs drop the pixel lying outside the rectangle; P==1 applies both rules.
          if (walk_first && walk_start_odd) wr_sel_d = wr_sel_d & ~PIXSEL_LEFT;
          if (walk_last && !walk_end_odd)   wr_sel_d = wr_sel_d & ~PIXSEL_RIGHT;
          state_d = WR;
        end
      end
      WR: begin
        o_busy  = 1'b1;
        o_wrReq = 1'b1;
        if (i_wrAck) begin
          if (walk_last && walk_last_line) begin
            state_d = DONE;
          end else begin
            walk_step = 1'b1;
            state_d   = POP;
          end
        end
      end
      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q   <= IDLE;
      wr_adr_q  <= '0;
      wr_data_q <= '0;
      wr_sel_q  <= '0;
    end else begin
      state_q   <= state_d;
      wr_adr_q  <= wr_adr_d;
      wr_data_q <= wr_data_d;
      wr_sel_q  <= wr_sel_d;
    end
  end

endmodule

// File: tb/tb_cv_write_state.sv
// Directed bench for cv_write_state with a FIFO model and a write scoreboard.
// Latency: n/a.
// Backpressure: randomised write-ack delay.
module tb_cv_write_state;

  localparam int DATA_W = 32;
  localparam int XW     = 10;
  localparam int YW     = 9;
  localparam int AW     = XW + YW - 1;

  logic              clk = 1'b0;
  logic              nRst;
  logic              i_start;
  logic [XW-1:0]     i_dstX;
  logic [YW-1:0]     i_dstY;
  logic [XW:0]       i_w;
  logic [YW:0]       i_h;
  logic              i_forceMask;
  logic              i_fifoEmpty;
  logic              o_fifoPop;
  logic [DATA_W-1:0] i_fifoData;
  logic              o_wrReq;
  logic [AW-1:0]     o_wrAdr;
  logic [DATA_W-1:0] o_wrData;
  logic [1:0]        o_wrSel;
  logic              i_wrAck;
  logic              o_busy;
  logic              o_done;

  cv_write_state #(.DATA_W(DATA_W), .XW(XW), .YW(YW)) dut (
    .clk         (clk),
    .nRst        (nRst),
    .i_start     (i_start),
    .i_dstX      (i_dstX),
    .i_dstY      (i_dstY),
    .i_w         (i_w),
    .i_h         (i_h),
    .i_forceMask (i_forceMask),
    .i_fifoEmpty (i_fifoEmpty),
    .o_fifoPop   (o_fifoPop),
    .i_fifoData  (i_fifoData),
    .o_wrReq     (o_wrReq),
    .o_wrAdr     (o_wrAdr),
    .o_wrData    (o_wrData),
    .o_wrSel     (o_wrSel),
    .i_wrAck     (i_wrAck),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]     adr;
    logic [DATA_W-1:0] data;
    logic [1:0]        sel;
  } wr_t;

  logic [DATA_W-1:0] fifo_q[$];
  wr_t               exp_q[$];
  logic              pop_flag = 1'b0;
  int                errors = 0;
  int                checks = 0;

  // FIFO model: a pop seen mid-cycle is consumed just after the following edge.
  always @(negedge clk) pop_flag = o_fifoPop && nRst;
  always @(posedge clk) begin
    #1;
    if (pop_flag && fifo_q.size() > 0) void'(fifo_q.pop_front());
    i_fifoEmpty = (fifo_q.size() == 0);
    i_fifoData  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: enumerate every word touched by pixels dx..dx+w-1 on each line, independent of P.
  task automatic build_rect(input int dx, input int dy, input int w, input int h,
                            input bit fm, input logic [31:0] base_data);
    int n = 0;
    for (int line = 0; line < h; line++) begin
      int a0 = dx;
      int a1 = dx + w - 1;
      for (int k = a0 / 2; k <= a1 / 2; k++) begin
        wr_t e;
        logic [DATA_W-1:0] d;
        d = base_data + 32'h0101_0101 * n;
        n++;
        e.adr    = AW'(((dy + line) % 512) * 512 + (k % 512));
        e.sel[0] = (2 * k >= a0);
        e.sel[1] = (2 * k + 1 <= a1);
`ifdef CVWRITE_FORCEMASK_EN
        e.data = fm ? (d | 32'h8000_8000) : d;
`else
        e.data = d;
`endif
        fifo_q.push_back(d);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic start_rect(input int dx, input int dy, input int w, input int h, input bit fm);
    @(negedge clk);
    i_dstX      = XW'(dx);
    i_dstY      = YW'(dy);
    i_w         = (XW+1)'(w);
    i_h         = (YW+1)'(h);
    i_forceMask = fm;
    i_start     = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("busy_after_start", 64'(o_busy), 64'd1);
  endtask

  task automatic service_writes(input int n, input int maxd);
    for (int k = 0; k < n; k++) begin
      int  cyc = 0;
      int  d;
      wr_t e;
      while (!o_wrReq && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      check("req_timeout", 64'(o_wrReq), 64'd1);
      if (!o_wrReq || exp_q.size() == 0) return;
      e = exp_q.pop_front();
      check("wr_adr", 64'(o_wrAdr), 64'(e.adr));
      check("wr_data", 64'(o_wrData), 64'(e.data));
      check("wr_sel", 64'(o_wrSel), 64'(e.sel));
      d = $urandom_range(0, maxd);
      for (int j = 0; j < d; j++) begin
        @(negedge clk);
        check("hold_req", 64'(o_wrReq), 64'd1);
        check("hold_adr", 64'(o_wrAdr), 64'(e.adr));
        check("hold_data", 64'(o_wrData), 64'(e.data));
        check("hold_sel", 64'(o_wrSel), 64'(e.sel));
      end
      i_wrAck = 1'b1;
      @(negedge clk);
      i_wrAck = 1'b0;
    end
    check("done_pulse", 64'(o_done), 64'd1);
    check("req_in_done", 64'(o_wrReq), 64'd0);
    @(negedge clk);
    check("done_one_cycle", 64'(o_done), 64'd0);
    check("busy_idle", 64'(o_busy), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    nRst        = 1'b0;
    i_start     = 1'b0;
    i_dstX      = '0;
    i_dstY      = '0;
    i_w         = '0;
    i_h         = '0;
    i_forceMask = 1'b0;
    i_fifoEmpty = 1'b1;
    i_fifoData  = '0;
    i_wrAck     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pop", 64'(o_fifoPop), 64'd0);
    check("rst_req", 64'(o_wrReq), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    check("rst_adr_data_sel", {o_wrAdr, o_wrData, o_wrSel}, 64'd0);
    nRst = 1'b1;
    @(negedge clk);

    // T1: aligned 4x2, FIFO preloaded
    build_rect(0, 0, 4, 2, 1'b0, 32'h1111_0000);
    start_rect(0, 0, 4, 2, 1'b0);
    service_writes(4, 0);

    // T2: odd start, 3 pairs with partial edges
    build_rect(1, 10, 4, 1, 1'b0, 32'h2222_0000);
    start_rect(1, 10, 4, 1, 1'b0);
    service_writes(3, 1);

    // T3: X and Y wrap
    build_rect(1022, 511, 4, 2, 1'b0, 32'h3333_0000);
    start_rect(1022, 511, 4, 2, 1'b0);
    service_writes(4, 2);

    // T4: single pixel, random ack delay
    build_rect(5, 3, 1, 1, 1'b0, 32'h4444_0000);
    start_rect(5, 3, 1, 1, 1'b0);
    service_writes(1, 5);

    // T6: mask forcing (expectation follows the build option)
    build_rect(8, 4, 2, 1, 1'b1, 32'h1234_0567);
    start_rect(8, 4, 2, 1, 1'b1);
    service_writes(1, 0);

    // Odd start + odd width across a line change, with random backpressure
    build_rect(3, 100, 5, 3, 1'b0, 32'h5555_0000);
    start_rect(3, 100, 5, 3, 1'b0);
    service_writes(9, 3);

    // T5: stall on empty FIFO, then reset while in WR
    start_rect(2, 2, 2, 1, 1'b0);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      check("stall_pop", 64'(o_fifoPop), 64'd0);
      check("stall_req", 64'(o_wrReq), 64'd0);
      check("stall_busy", 64'(o_busy), 64'd1);
    end
    build_rect(2, 2, 2, 1, 1'b0, 32'h6666_0000);
    begin
      int cyc = 0;
      while (!o_wrReq && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
    end
    check("req_after_stall", 64'(o_wrReq), 64'd1);
    nRst = 1'b0;
    @(negedge clk);
    check("rst_mid_req", 64'(o_wrReq), 64'd0);
    check("rst_mid_busy", 64'(o_busy), 64'd0);
    check("rst_mid_done", 64'(o_done), 64'd0);
    check("rst_mid_sel", 64'(o_wrSel), 64'd0);
    nRst = 1'b1;
    exp_q.delete();
    fifo_q.delete();
    repeat (2) @(negedge clk);
    check("idle_after_rst", 64'(o_busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
